// File: rtl/spi_burst_sequencer.sv
// Burst sequencer in front of a single-CS SPI master: sends one command's bytes one at a time,
// collects the returned RX bytes and hands back one packed response, with an RX timeout watchdog.
module spi_burst_sequencer #(
    parameter int unsigned MAX_BYTES_PER_CS = 4,
    parameter int unsigned TIMEOUT_CLKS     = 1024,
    localparam int unsigned CW = $clog2(MAX_BYTES_PER_CS + 1),
    localparam int unsigned DW = 8 * MAX_BYTES_PER_CS,
    localparam int unsigned TW = $clog2(TIMEOUT_CLKS + 1)
) (
    input  logic          i_Clk,
    input  logic          i_Rst,
    input  logic          i_Cmd_Valid,
    output logic          o_Cmd_Ready,
    input  logic [CW-1:0] i_Cmd_Count,
    input  logic [DW-1:0] i_Cmd_Data,
    output logic          o_Rsp_Valid,
    input  logic          i_Rsp_Ready,
    output logic [DW-1:0] o_Rsp_Data,
    output logic          o_Rsp_Err,
    output logic [CW-1:0] o_TX_Count,
    output logic [7:0]    o_TX_Byte,
    output logic          o_TX_DV,
    input  logic          i_TX_Ready,
    input  logic          i_RX_DV,
    input  logic [7:0]    i_RX_Byte
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SEND    = 2'd1,
        ST_WAIT_RX = 2'd2,
        ST_RESP    = 2'd3
    } state_t;

    localparam logic [TW-1:0] TIMER_MAX  = {TW{1'b1}};
    localparam logic [TW-1:0] TIMER_LIM  = TW'(TIMEOUT_CLKS);
    localparam logic [CW-1:0] COUNT_MAX  = CW'(MAX_BYTES_PER_CS);

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [DW-1:0] tx_buf_q, tx_buf_d;
    logic [DW-1:0] rx_buf_q, rx_buf_d;
    logic [CW-1:0] tx_idx_q, tx_idx_d;
    logic [CW-1:0] rx_idx_q, rx_idx_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          cmd_ready_q, cmd_ready_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic [DW-1:0] rsp_data_q, rsp_data_d;
    logic          rsp_err_q, rsp_err_d;
    logic [CW-1:0] tx_count_q, tx_count_d;
    logic [7:0]    tx_byte_q, tx_byte_d;
    logic          tx_dv_q, tx_dv_d;

    logic [7:0]    tx_sel_c;
    logic [DW-1:0] rx_buf_wr_c;
    logic [CW-1:0] rx_idx_nxt_c;
    logic [TW-1:0] timer_inc_c;

    // Byte lane select for the next TX byte and merge of the incoming RX byte.
    always_comb begin
        tx_sel_c    = 8'h00;
        rx_buf_wr_c = rx_buf_q;
        for (int unsigned i = 0; i < MAX_BYTES_PER_CS; i++) begin
            if (tx_idx_q == CW'(i)) begin
                tx_sel_c = tx_buf_q[8*i +: 8];
            end
            if (rx_idx_q == CW'(i)) begin
                rx_buf_wr_c[8*i +: 8] = i_RX_Byte;
            end
        end
        rx_idx_nxt_c = rx_idx_q + CW'(1);
        timer_inc_c  = (timer_q == TIMER_MAX) ? timer_q : timer_q + TW'(1);
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        tx_buf_d    = tx_buf_q;
        rx_buf_d    = rx_buf_q;
        tx_idx_d    = tx_idx_q;
        rx_idx_d    = rx_idx_q;
        timer_d     = timer_q;
        cmd_ready_d = cmd_ready_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_err_d   = rsp_err_q;
        tx_count_d  = tx_count_q;
        tx_byte_d   = tx_byte_q;
        tx_dv_d     = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                cmd_ready_d = 1'b1;
                if (i_Cmd_Valid && cmd_ready_q) begin
                    cmd_ready_d = 1'b0;
                    cnt_d       = i_Cmd_Count;
                    tx_buf_d    = i_Cmd_Data;
                    rx_buf_d    = '0;
                    tx_idx_d    = '0;
                    rx_idx_d    = '0;
                    timer_d     = '0;
                    if (i_Cmd_Count == '0 || i_Cmd_Count > COUNT_MAX) begin
                        state_d     = ST_RESP;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                        rsp_data_d  = '0;
                    end else begin
                        tx_count_d = i_Cmd_Count;
                        // Master already ready: launch byte 0 straight from the accept cycle.
                        if (i_TX_Ready) begin
                            tx_dv_d   = 1'b1;
                            tx_byte_d = i_Cmd_Data[7:0];
                            tx_idx_d  = CW'(1);
                            state_d   = ST_WAIT_RX;
                        end else begin
                            state_d = ST_SEND;
                        end
                    end
                end
            end

            ST_SEND: begin
                if (i_TX_Ready && rx_idx_q == tx_idx_q) begin
                    tx_dv_d   = 1'b1;
                    tx_byte_d = tx_sel_c;
                    tx_idx_d  = tx_idx_q + CW'(1);
                    timer_d   = '0;
                    state_d   = ST_WAIT_RX;
                end
            end

            ST_WAIT_RX: begin
                // An RX strobe beats a timeout expiring in the same cycle.
                if (i_RX_DV) begin
                    rx_buf_d = rx_buf_wr_c;
                    rx_idx_d = rx_idx_nxt_c;
                    timer_d  = '0;
                    if (rx_idx_nxt_c == cnt_q) begin
                        state_d     = ST_RESP;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b0;
                        rsp_data_d  = rx_buf_wr_c;
                        tx_count_d  = '0;
                    end else begin
                        state_d = ST_SEND;
                    end
                end else begin
                    timer_d = timer_inc_c;
                    if (timer_inc_c >= TIMER_LIM) begin
                        state_d     = ST_RESP;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                        rsp_data_d  = rx_buf_q;
                        tx_count_d  = '0;
                    end
                end
            end

            ST_RESP: begin
                if (i_Rsp_Ready) begin
                    rsp_valid_d = 1'b0;
                    rsp_err_d   = 1'b0;
                    rsp_data_d  = '0;
                    cmd_ready_d = 1'b1;
                    state_d     = ST_IDLE;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            tx_buf_q    <= '0;
            rx_buf_q    <= '0;
            tx_idx_q    <= '0;
            rx_idx_q    <= '0;
            timer_q     <= '0;
            cmd_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
            tx_count_q  <= '0;
            tx_byte_q   <= 8'h00;
            tx_dv_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            tx_buf_q    <= tx_buf_d;
            rx_buf_q    <= rx_buf_d;
            tx_idx_q    <= tx_idx_d;
            rx_idx_q    <= rx_idx_d;
            timer_q     <= timer_d;
            cmd_ready_q <= cmd_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
            tx_count_q  <= tx_count_d;
            tx_byte_q   <= tx_byte_d;
            tx_dv_q     <= tx_dv_d;
        end
    end

    assign o_Cmd_Ready = cmd_ready_q;
    assign o_Rsp_Valid = rsp_valid_q;
    assign o_Rsp_Data  = rsp_data_q;
    assign o_Rsp_Err   = rsp_err_q;
    assign o_TX_Count  = tx_count_q;
    assign o_TX_Byte   = tx_byte_q;
    assign o_TX_DV     = tx_dv_q;

endmodule
